// File: rtl/regfile_sequencer.sv
// regfile_sequencer: Moore control FSM that sequences register-file, ALU and bus control for a 10-bit instruction set.
// Ports: CLKb/RSTb (async active-low reset); EXEC/INSTR capture an instruction in T0;
// ENW/WRA write port; ENR0/RDA0 and ENR1/RDA1 read ports; EXTRN, ALOAD, ALU_OP, GLOAD, GOUT datapath
// controls; DONE/ERR completion pulses; BUSY high outside T0.
// Optional macro REGSEQ_RETIRE_CNT_EN adds parameter CNT_W and output RETIRED (count of legal retired instructions).
module regfile_sequencer #(
  parameter int IW = 10
`ifdef REGSEQ_RETIRE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic          CLKb,
  input  logic          RSTb,
  input  logic          EXEC,
  input  logic [IW-1:0] INSTR,
  output logic          ENW,
  output logic [1:0]    WRA,
  output logic          ENR0,
  output logic [1:0]    RDA0,
  output logic          ENR1,
  output logic [1:0]    RDA1,
  output logic          EXTRN,
  output logic          ALOAD,
  output logic [2:0]    ALU_OP,
  output logic          GLOAD,
  output logic          GOUT,
  output logic          DONE,
  output logic          ERR,
  output logic          BUSY
`ifdef REGSEQ_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] RETIRED
`endif
);
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [1:0] rx, ry;
  logic [3:0] op;
  logic is_load, is_copy, is_alu, is_ill, t1, t2, t3;
  logic unused;
  always_comb begin
    rx      = ir_q[9:8];
    ry      = ir_q[7:6];
    op      = ir_q[3:0];
    unused  = ^ir_q[5:4];
    is_load = op == 4'b0000;
    is_copy = op == 4'b0001;
    is_ill  = op[3];
    is_alu  = !op[3] && op[2:1] != 2'b00;
    t1      = state_q == T1;
    t2      = state_q == T2;
    t3      = state_q == T3;
    // Outputs depend only on state and IR; everything not driven in a state is 0.
    ENW     = (t1 && (is_load || is_copy)) || t3;
    WRA     = ENW ? rx : 2'b00;
    ENR0    = t1 && (is_copy || is_alu);
    RDA0    = !t1 ? 2'b00 : is_copy ? ry : is_alu ? rx : 2'b00;
    ENR1    = t2;
    RDA1    = t2 ? ry : 2'b00;
    EXTRN   = t1 && is_load;
    ALOAD   = t1 && is_alu;
    // Opcodes 0010..0111 map onto ALU functions 000..101.
    ALU_OP  = t2 ? op[2:0] - 3'd2 : 3'd0;
    GLOAD   = t2;
    GOUT    = t3;
    DONE    = (t1 && !is_alu) || t3;
    ERR     = t1 && is_ill;
    BUSY    = state_q != T0;
    ir_d    = (state_q == T0 && EXEC) ? INSTR : ir_q;
    state_d = state_q == T0 ? (EXEC ? T1 : T0) :
              state_q == T1 ? (is_alu ? T2 : T0) :
              state_q == T2 ? T3 : T0;
  end
`ifdef REGSEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  always_comb begin
    retired_d = retired_q + CNT_W'(DONE && !ERR);
    RETIRED   = retired_q;
  end
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) retired_q <= '0;
    else retired_q <= retired_d;
  end
`endif
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed self-checking bench for regfile_sequencer with a small register-file/ALU environment.
module tb_regfile_sequencer;
  logic CLKb = 0, RSTb = 0, EXEC = 0;
  logic [9:0] INSTR = '0;
  logic ENW, ENR0, ENR1, EXTRN, ALOAD, GLOAD, GOUT, DONE, ERR, BUSY;
  logic [1:0] WRA, RDA0, RDA1;
  logic [2:0] ALU_OP;
`ifdef REGSEQ_RETIRE_CNT_EN
  logic [1:0] RETIRED;
  regfile_sequencer #(.IW(10), .CNT_W(2)) dut (
`else
  regfile_sequencer #(.IW(10)) dut (
`endif
    .CLKb(CLKb), .RSTb(RSTb), .EXEC(EXEC), .INSTR(INSTR),
    .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
    .EXTRN(EXTRN), .ALOAD(ALOAD), .ALU_OP(ALU_OP), .GLOAD(GLOAD), .GOUT(GOUT),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
`ifdef REGSEQ_RETIRE_CNT_EN
    , .RETIRED(RETIRED)
`endif
  );
  always #5 CLKb = ~CLKb;
  logic [9:0] regs [4] = '{default: '0};
  logic [9:0] din = '0, a = '0, g = '0, q0, q1, bus, alu;
  logic [31:0] outs;
  always_comb begin
    q0   = regs[RDA0];
    q1   = regs[RDA1];
    bus  = EXTRN ? din : GOUT ? g : q0;
    alu  = ALU_OP == 3'd0 ? a + q1 : ALU_OP == 3'd1 ? a - q1 : ALU_OP == 3'd2 ? a & q1 :
           ALU_OP == 3'd3 ? a | q1 : ALU_OP == 3'd4 ? a ^ q1 : ~q1;
    outs = {13'b0, ENW, WRA, ENR0, RDA0, ENR1, RDA1, EXTRN, ALOAD, ALU_OP, GLOAD, GOUT, DONE, ERR, BUSY};
  end
  always @(negedge CLKb) if (ENW) regs[WRA] <= bus;
  always @(posedge CLKb) begin
    if (ALOAD) a <= q0;
    if (GLOAD) g <= alu;
  end
  int n_chk = 0, n_pass = 0, exp_ret = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic [31:0] ov(input int enw, wra, enr0, rda0, enr1, rda1, extrn, aload,
                                     aluop, gload, gout, done, err, busy);
    return {13'b0, 1'(enw), 2'(wra), 1'(enr0), 2'(rda0), 1'(enr1), 2'(rda1), 1'(extrn), 1'(aload),
            3'(aluop), 1'(gload), 1'(gout), 1'(done), 1'(err), 1'(busy)};
  endfunction
  task automatic step;
    @(posedge CLKb);
    #1;
  endtask
  task automatic issue(input logic [9:0] i);
    INSTR = i;
    EXEC = 1;
    step();
    EXEC = 0;
    INSTR = ~i;
  endtask
  task automatic do_load(input int r, input logic [9:0] v);
    din = v;
    issue({2'(r), 8'b0000_0000});
    chk("load_t1", outs, ov(1, r, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    step();
    chk("load_idle", outs, 0);
    exp_ret++;
  endtask
  task automatic alu3(input logic [9:0] i, input int rx, ry, aop);
    issue(i);
    chk("alu_t1", outs, ov(0, 0, 1, rx, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    step();
    chk("alu_t2", outs, ov(0, 0, 0, 0, 1, ry, 0, 0, aop, 1, 0, 0, 0, 1));
    step();
    chk("alu_t3", outs, ov(1, rx, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    step();
    chk("alu_idle", outs, 0);
    exp_ret++;
  endtask
  initial begin
    step();
    chk("reset", outs, 0);
    RSTb = 1;
    step();
    chk("idle", outs, 0);
    do_load(1, 10'h155);
    do_load(2, 10'h3FF);
    do_load(3, 10'h002);
    do_load(0, 10'h156);
    chk("r1_loaded", 32'(regs[1]), 32'h155);
    alu3(10'b10_11_00_0010, 2, 3, 0);
    chk("add_wrap", 32'(regs[2]), 32'h001);
    issue(10'b00_01_00_1010);
    chk("ill_t1", outs, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    step();
    chk("ill_idle", outs, 0);
    chk("ill_regs", 32'({regs[0], regs[1], regs[2]}), 32'({10'h156, 10'h155, 10'h001}));
    INSTR = 10'b01_00_00_0011;
    EXEC = 1;
    step();
    chk("sub_t1", outs, ov(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    step();
    chk("sub_t2", outs, ov(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    INSTR = 10'b00_10_00_0001;
    step();
    chk("sub_t3", outs, ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    step();
    chk("b2b_idle", outs, 0);
    step();
    chk("copy_t1", outs, ov(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    EXEC = 0;
    step();
    chk("copy_idle", outs, 0);
    chk("sub_wrap", 32'(regs[1]), 32'h3FF);
    chk("copy_r0", 32'(regs[0]), 32'h001);
    exp_ret += 2;
    alu3(10'b11_01_00_0111, 3, 1, 5);
    chk("not_r3", 32'(regs[3]), 32'h000);
    alu3(10'b10_10_00_0010, 2, 2, 0);
    chk("add_self", 32'(regs[2]), 32'h002);
    alu3(10'b01_10_00_0110, 1, 2, 4);
    chk("xor_r1", 32'(regs[1]), 32'h3FD);
    alu3(10'b11_00_00_0101, 3, 0, 3);
    chk("or_r3", 32'(regs[3]), 32'h001);
    alu3(10'b01_00_00_0100, 1, 0, 2);
    chk("and_r1", 32'(regs[1]), 32'h001);
`ifdef REGSEQ_RETIRE_CNT_EN
    chk("retired_wrap", 32'(RETIRED), 32'(exp_ret % 4));
`endif
    issue(10'b01_11_00_0010);
    step();
    chk("rst_pre_t2", outs, ov(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 1));
    RSTb = 0;
    #1;
    chk("rst_async", outs, 0);
    step();
    chk("rst_hold", outs, 0);
    RSTb = 1;
    step();
    chk("rst_idle", outs, 0);
    chk("rst_no_write", 32'(regs[1]), 32'h001);
    exp_ret = 0;
    do_load(2, 10'h0AA);
    chk("load_after_rst", 32'(regs[2]), 32'h0AA);
`ifdef REGSEQ_RETIRE_CNT_EN
    chk("retired_after_rst", 32'(RETIRED), 32'(exp_ret % 4));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
